riscv_mdu_seq: RTL and testbench
================================

Name: riscv_mdu_seq

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply-divide unit.
- Sits beside the single-cycle integer ALU in the EX stage and executes all eight M-extension ops (funct3-encoded).
- Iterative radix-2 datapath with valid/ready handshakes on both the input and result sides, so the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  reset, synchronous, active-low.
- i_mdu_valid  input  1  request valid.
- o_mdu_ready  output  1  unit can accept a request; high only in IDLE.
- i_mdu_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_mdu_a  input  XLEN  rs1 operand.
- i_mdu_b  input  XLEN  rs2 operand.
- i_mdu_flush  input  1  abort the current operation (branch/trap kill).
- o_mdu_valid  output  1  result valid; held until accepted.
- i_mdu_rready  input  1  consumer takes the result.
- o_mdu_result  output  XLEN  result.
- o_mdu_busy  output  1  state != IDLE.

Behaviour:
- Accept: on an edge where i_mdu_valid && o_mdu_ready && !i_mdu_flush.
  - Latch op and operand magnitudes.
  - Latch result-sign flags: MUL/MULH signed x signed; MULHSU signed a, unsigned b; DIV/REM signed.
- States: IDLE -> CALC -> DONE -> IDLE.
  - IDLE: o_mdu_ready=1.
  - CALC: counter runs 0..XLEN-1, one partial-product add or one restoring-divide step per cycle.
  - DONE: o_mdu_valid=1. On i_mdu_rready the state goes to IDLE; a new request is not accepted in that same cycle.
- Latency: o_mdu_valid rises XLEN+1 edges after the accept edge (33 for XLEN=32).
- Sign fixup happens on the CALC->DONE edge.
- Multiply: 2*XLEN unsigned product of magnitudes, negated if the operand signs differ.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
- Divide: quotient negated if signs differ; remainder takes the dividend's sign.
- Special cases skip CALC; IDLE->DONE on the accept edge, valid the next cycle:
  - Divide by zero (b==0): DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow (a = 1<<(XLEN-1), b = all ones): DIV = a; REM = 0.
- Backpressure: in DONE with i_mdu_rready=0, o_mdu_result and o_mdu_valid hold stable indefinitely.
- Flush:
  - i_mdu_flush=1 in any state forces IDLE at the next edge and clears o_mdu_valid.
  - Flush beats accept in the same cycle.
  - Flush in DONE discards the result even if i_mdu_rready=1.
- Reset (i_rstn=0 at an edge), including mid-operation:
  - state=IDLE, counter=0, o_mdu_result=0, o_mdu_valid=0, o_mdu_busy=0.
  - o_mdu_ready=1 from the first cycle after reset.
- Inputs i_mdu_a/b/op are don't-care after the accept edge; internal copies are used.
- o_mdu_result is registered, with no combinational path from the inputs.

Optional Feature:
- Macro: RISCV_MDU_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle XLEN x XLEN multiplier.
  - IDLE->DONE on the accept edge; o_mdu_valid the next cycle, i.e. latency 1.
  - Divide ops are unchanged.
- Undefined: all multiplies use the iterative path with latency XLEN+1, and no wide multiplier is inferred.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB.
  - o_mdu_valid after 33 edges, or 1 edge with RISCV_MDU_FAST_MUL_EN.
  - o_mdu_ready low throughout.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Special cases, each with valid 1 edge after accept:
  - DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure and flush:
  - Hold i_mdu_rready=0 for 10 cycles in DONE -> result and valid stable.
  - Assert i_mdu_flush at CALC cycle 10 -> IDLE next edge, no valid pulse; a following request completes correctly.
- Reset mid-CALC: drive i_rstn=0 for 1 edge -> o_mdu_valid=0, o_mdu_result=0, o_mdu_ready=1 the next cycle; a new DIV 100/7 -> 14.

Source files
------------

// File: rtl/riscv_mdu_seq.sv
// riscv_mdu_seq: iterative RV32M/RV64M multiply-divide unit.
// Radix-2 shift-add multiplier and restoring divider share one 2*XLEN
// working register; signs are stripped on accept and restored on the
// CALC->DONE edge. Divide-by-zero and signed overflow bypass CALC.
// Optional macro RISCV_MDU_FAST_MUL_EN: multiplies use a single-cycle
// XLEN x XLEN multiplier and complete on the accept edge.
module riscv_mdu_seq #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_mdu_valid,
  output logic            o_mdu_ready,
  input  logic [2:0]      i_mdu_op,
  input  logic [XLEN-1:0] i_mdu_a,
  input  logic [XLEN-1:0] i_mdu_b,
  input  logic            i_mdu_flush,
  output logic            o_mdu_valid,
  input  logic            i_mdu_rready,
  output logic [XLEN-1:0] o_mdu_result,
  output logic            o_mdu_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;     // product / quotient must be negated
  logic              rneg_q;    // remainder must be negated (dividend sign)
  logic [XLEN-1:0]   mcand_q;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0] prod_q;    // {hi, lo}: product, or {remainder, quotient}
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_res;
  logic              accept;

  // Apply sign fixup and pick the half / quotient / remainder the op wants
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] op,
                                            input logic [2*XLEN-1:0] p,
                                            input logic neg,
                                            input logic rneg);
    logic [2*XLEN-1:0] pn;
    logic [XLEN-1:0]   q, r;
    pn = neg  ? -p : p;
    q  = neg  ? -p[XLEN-1:0] : p[XLEN-1:0];
    r  = rneg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fixup = pn[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixup = pn[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixup = q;
      default:                fixup = r;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && i_mdu_valid && !i_mdu_flush;

  // Operand signedness per op, magnitudes and special-case detection
  always_comb begin
    a_sgn = 1'b1;
    b_sgn = 1'b1;
    case (i_mdu_op)
      3'b010:                 b_sgn = 1'b0;
      3'b011, 3'b101, 3'b111: begin a_sgn = 1'b0; b_sgn = 1'b0; end
      default: ;
    endcase
    a_neg    = a_sgn & i_mdu_a[XLEN-1];
    b_neg    = b_sgn & i_mdu_b[XLEN-1];
    mag_a    = a_neg ? -i_mdu_a : i_mdu_a;
    mag_b    = b_neg ? -i_mdu_b : i_mdu_b;
    div_zero = (i_mdu_b == '0);
    div_ovf  = (i_mdu_op == 3'b100 || i_mdu_op == 3'b110) &&
               (i_mdu_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_mdu_b == '1);
    if (!i_mdu_op[1]) spec_res = div_zero ? '1 : i_mdu_a;
    else              spec_res = div_zero ? i_mdu_a : '0;
  end

`ifdef RISCV_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] trial;
    sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh = prod_q[2*XLEN-1:XLEN-1];
    trial  = rem_sh[XLEN-1:0] - mcand_q;
    if (!op_q[2])
      prod_d = {sum, prod_q[XLEN-1:1]};
    else if (rem_sh < {1'b0, mcand_q})
      prod_d = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    else
      prod_d = {trial, prod_q[XLEN-2:0], 1'b1};
  end

  // Datapath registers: load magnitudes on accept, iterate while in CALC
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q    <= i_mdu_op;
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
      mcand_q <= i_mdu_op[2] ? mag_b : mag_a;
      prod_q  <= {{XLEN{1'b0}}, (i_mdu_op[2] ? mag_a : mag_b)};
    end else if (state_q == S_CALC) begin
      prod_q  <= prod_d;
    end
  end

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else if (i_mdu_flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_mdu_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (i_mdu_op[2] && (div_zero || div_ovf)) begin
              state_q  <= S_DONE;
              result_q <= spec_res;
              valid_q  <= 1'b1;
            end
`ifdef RISCV_MDU_FAST_MUL_EN
            else if (!i_mdu_op[2]) begin
              state_q  <= S_DONE;
              result_q <= fixup(i_mdu_op, fast_prod, a_neg ^ b_neg, a_neg);
              valid_q  <= 1'b1;
            end
`endif
            else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q  <= S_DONE;
            cnt_q    <= '0;
            result_q <= fixup(op_q, prod_d, neg_q, rneg_q);
            valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (i_mdu_rready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mdu_ready  = ready_q;
  assign o_mdu_valid  = valid_q;
  assign o_mdu_busy   = busy_q;
  assign o_mdu_result = result_q;

endmodule

// File: tb/tb_riscv_mdu_seq.sv
// Self-checking bench for riscv_mdu_seq (XLEN=32): directed and random
// ops scored every cycle against a plain-arithmetic reference model.
module tb_riscv_mdu_seq;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        rready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;

  int nchk = 0;
  int npass = 0;

  riscv_mdu_seq #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_mdu_valid(valid), .o_mdu_ready(o_ready),
    .i_mdu_op(op), .i_mdu_a(a), .i_mdu_b(b), .i_mdu_flush(flush),
    .o_mdu_valid(o_valid), .i_mdu_rready(rready), .o_mdu_result(o_result),
    .o_mdu_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference: M-extension results from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] pu;
    int ia, ib;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    ub = {32'b0, mb};
    ia = ma;
    ib = mb;
    model = '0;
    case (mop)
      3'd0: begin p = sa * sb; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin pu = {32'b0, ma} * {32'b0, mb}; model = pu[63:32]; end
      3'd4: if (mb == 0) model = '1; else if (ma == MIN && mb == '1) model = ma; else model = 32'(ia / ib);
      3'd5: if (mb == 0) model = '1; else model = ma / mb;
      3'd6: if (mb == 0) model = ma; else if (ma == MIN && mb == '1) model = '0; else model = 32'(ia % ib);
      default: if (mb == 0) model = ma; else model = ma % mb;
    endcase
  endfunction

  // Edges from accept (counted as edge 1) until valid is visible
  function automatic int exp_latency(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    if (mop[2]) begin
      if (mb == 0) return 1;
      if ((mop == 3'd4 || mop == 3'd6) && ma == MIN && mb == '1) return 1;
      return 33;
    end
`ifdef RISCV_MDU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Scoreboard: track the outstanding op and check outputs every cycle
  bit          pending = 1'b0;
  int          lat = 0;
  int          elat = 0;
  logic [31:0] eres = '0;

  always @(posedge clk) begin
    bit acc, take, kill, in_rst;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b;
    in_rst = !rstn;
    kill   = flush || !rstn;
    acc    = valid && (o_ready === 1'b1) && !kill;
    take   = (o_valid === 1'b1) && rready && !kill;
    s_op = op; s_a = a; s_b = b;
    #1;
    if (kill) begin
      pending = 1'b0;
      chk("kill_valid", o_valid, 0);
      chk("kill_ready", o_ready, 1);
      chk("kill_busy", o_busy, 0);
      if (in_rst) chk("rst_result", o_result, 0);
    end else begin
      if (acc) begin
        pending = 1'b1;
        lat  = 1;
        eres = model(s_op, s_a, s_b);
        elat = exp_latency(s_op, s_a, s_b);
      end else if (take) begin
        pending = 1'b0;
      end else if (pending) begin
        lat++;
      end
      if (pending) begin
        chk("busy_ready", o_ready, 0);
        chk("busy_busy", o_busy, 1);
        if (lat < elat) chk("early_valid", o_valid, 0);
        else begin
          chk("valid", o_valid, 1);
          chk("result", o_result, eres);
        end
      end else begin
        chk("idle_valid", o_valid, 0);
        chk("idle_ready", o_ready, 1);
        chk("idle_busy", o_busy, 0);
      end
    end
  end

  task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
    int w = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("ready_timeout", 0, 1);
    valid = 1'b1; op = iop; a = ia; b = ib;
    @(negedge clk);
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input int hold);
    int w = 0;
    while (o_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) chk("valid_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic run(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib, input int hold);
    issue(iop, ia, ib);
    wait_result(hold);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Pin the reference model to hand-computed values
    chk("pin_mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh",   model(3'd1, MIN, MIN), 32'h4000_0000);
    chk("pin_mulhu",  model(3'd3, MIN, MIN), 32'h4000_0000);
    chk("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_divu",   model(3'd5, 32'd100, 32'd7), 32'd14);
    chk("pin_remu",   model(3'd7, 32'd100, 32'd7), 32'd2);
    chk("pin_divu0",  model(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin_remu0",  model(3'd7, 32'd5, 32'd0), 32'd5);
    chk("pin_divovf", model(3'd4, MIN, 32'hFFFF_FFFF), MIN);
    chk("pin_removf", model(3'd6, MIN, 32'hFFFF_FFFF), 32'd0);
    chk("pin_lat",    exp_latency(3'd5, 32'd5, 32'd0), 1);

    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Directed cases; the MUL holds the result for 10 cycles of backpressure
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 10);
    run(3'd1, MIN, MIN, 0);
    run(3'd3, MIN, MIN, 0);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run(3'd5, 32'd100, 32'd7, 0);
    run(3'd7, 32'd100, 32'd7, 0);
    run(3'd5, 32'd5, 32'd0, 2);
    run(3'd7, 32'd5, 32'd0, 0);
    run(3'd4, MIN, 32'hFFFF_FFFF, 0);
    run(3'd6, MIN, 32'hFFFF_FFFF, 0);

    // Flush at CALC cycle 10, then a normal request
    issue(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run(3'd5, 32'd1000, 32'd3, 0);

    // Flush beats a simultaneous request
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;

    // Flush in DONE discards the result even with rready high
    issue(3'd7, 32'd11, 32'd0);
    flush = 1'b1; rready = 1'b1;
    @(negedge clk);
    flush = 1'b0; rready = 1'b0;

    // Reset mid-CALC, then DIVU 100/7
    issue(3'd0, 32'd123, 32'd456);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run(3'd5, 32'd100, 32'd7, 0);

    // Random ops with random backpressure and occasional flushes
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom);
      ra  = rnd_val();
      rb  = rnd_val();
      if ($urandom_range(0, 5) == 0) begin
        issue(rop, ra, rb);
        repeat ($urandom_range(0, 40)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end else begin
        run(rop, ra, rb, $urandom_range(0, 3));
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
